qbert_button_pio: RTL and testbench

Parametrised Avalon-MM input PIO for the Qbert push-buttons. It is the successor to the single-bit button port and adds a configurable width, a 2-flop synchroniser, a per-bit debounce filter, per-bit edge capture with write-1-to-clear, and a maskable level interrupt to the NIOS. It sits between the board button pins and the NIOS data bus, with its irq routed to the processor's interrupt controller.

---
 rtl/qbert_button_pio_if.sv | 19 +
 rtl/qbert_button_pio.sv | 115 +++++++++++
 tb/tb_qbert_button_pio.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/qbert_button_pio_if.sv
// Avalon-MM slave bus bundle for the Qbert button PIO: register select,
// write strobe/data and registered read data.
interface qbert_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qbert_button_pio.sv
// Qbert push-button input PIO: 2-flop synchroniser, per-bit debounce,
// sticky edge capture with write-1-to-clear and a maskable level irq.
module qbert_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  qbert_button_pio_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_V  = {WIDTH{1'(IDLE_LEVEL)}};

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic             wr_s;
  logic [WIDTH-1:0] upd_s, set_s, clr_s;

  // Debounce, edge capture, register writes and read mux.
  always_comb begin
    wr_s  = bus.chipselect & ~bus.write_n;
    deb_d = deb_q;
    upd_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
        upd_s[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    if (EDGE_TYPE == 0) begin
      set_s = upd_s & deb_d;
    end else if (EDGE_TYPE == 1) begin
      set_s = upd_s & ~deb_d;
    end else begin
      set_s = upd_s;
    end

    if (wr_s && (bus.address == 2'd3)) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    // Set after clear so a coincident capture survives the clear.
    edge_d = (edge_q & ~clr_s) | set_s;

    if (wr_s && (bus.address == 2'd1)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end

    case (bus.address)
      2'd0:    rdata_d = 32'(deb_q);
      2'd1:    rdata_d = 32'(mask_q);
      2'd3:    rdata_d = 32'(edge_q);
      default: rdata_d = 32'h0000_0000;
    endcase

    irq_d = |(edge_q & mask_q);
  end

  // State registers with synchronous reset to the idle input level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= IDLE_V;
      s2_q    <= IDLE_V;
      deb_q   <= IDLE_V;
      cnt_q   <= '{default: '0};
      mask_q  <= '0;
      edge_q  <= '0;
      rdata_q <= 32'h0000_0000;
      irq_q   <= 1'b0;
    end else begin
      s1_q    <= in_port;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata_s;
      assign unused_wdata_s = ^bus.writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_qbert_button_pio.sv
// Directed self-checking bench for qbert_button_pio (WIDTH=4, DEBOUNCE=4,
// falling-edge capture, idle-high inputs).
module tb_qbert_button_pio;
  logic       clk;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;
  int         errors;
  int         checks;
  logic [31:0] rd;

  qbert_button_pio_if bus ();

  qbert_button_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    in_port = 4'hF;
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'h0;

    // 1: reset values at every address, then debounced idle level
    ticks(2);
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      tick();
      check_val($sformatf("rst_rd%0d", a), bus.readdata, 32'h0);
      check_val("rst_irq", {31'b0, irq}, 32'h0);
    end
    reset = 1'b0;
    bus_read(2'd0, rd); check_val("idle_data", rd, 32'h0000_000F);
    bus_read(2'd1, rd); check_val("idle_mask", rd, 32'h0);
    bus_read(2'd3, rd); check_val("idle_edge", rd, 32'h0);

    // 2: falling edge on bit 0, latency to capture and irq
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd); check_val("mask_rb", rd, 32'h1);
    in_port = 4'hE;
    bus.address = 2'd3;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_val($sformatf("lat_edge_t%0d", i), bus.readdata, (i == 7) ? 32'h1 : 32'h0);
      check_val($sformatf("lat_irq_t%0d", i), {31'b0, irq}, (i == 7) ? 32'h1 : 32'h0);
    end
    bus_read(2'd0, rd); check_val("fall_data", rd, 32'h0000_000E);

    // Return to idle (rising edge is not captured), clear edges
    in_port = 4'hF;
    ticks(8);
    bus_read(2'd3, rd); check_val("rise_nocap", rd, 32'h1);
    bus_write(2'd3, 32'hF);
    tick();
    check_val("clr_irq", {31'b0, irq}, 32'h0);

    // 3: 3-cycle glitch on bit 1 is rejected
    in_port = 4'hD;
    ticks(3);
    in_port = 4'hF;
    ticks(8);
    bus_read(2'd0, rd); check_val("glitch_data", rd, 32'h0000_000F);
    bus_read(2'd3, rd); check_val("glitch_edge", rd, 32'h0);
    check_val("glitch_irq", {31'b0, irq}, 32'h0);

    // 4: clear coincident with accepted falling edge; set wins
    in_port = 4'hE;
    ticks(5);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd); check_val("setwins_edge", rd, 32'h1);
    check_val("setwins_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check_val("clr2_irq_same", {31'b0, irq}, 32'h1);
    tick();
    check_val("clr2_irq_next", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check_val("clr2_edge", rd, 32'h0);

    // 5: mask gating with captures held
    bus_write(2'd1, 32'h0);
    in_port = 4'hF;
    ticks(8);
    in_port = 4'hC;
    ticks(8);
    check_val("m0_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check_val("m_edge3", rd, 32'h3);
    bus_read(2'd0, rd); check_val("m_data", rd, 32'h0000_000C);
    bus_write(2'd1, 32'h2);
    check_val("m2_irq_same", {31'b0, irq}, 32'h0);
    tick();
    check_val("m2_irq_next", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'h0);
    check_val("m0b_irq_same", {31'b0, irq}, 32'h1);
    tick();
    check_val("m0b_irq_next", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check_val("m_edge_kept", rd, 32'h3);
    bus_read(2'd2, rd); check_val("reserved", rd, 32'h0);

    // 6: reset two cycles into a debounce, then timing after release
    in_port = 4'h7;
    ticks(4);
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      tick();
      check_val($sformatf("rst2_rd%0d", a), bus.readdata, 32'h0);
      check_val("rst2_irq", {31'b0, irq}, 32'h0);
    end
    bus.address = 2'd3;
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_val($sformatf("post_edge_t%0d", i), bus.readdata, (i == 7) ? 32'h8 : 32'h0);
    end
    check_val("post_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, rd); check_val("post_data", rd, 32'h0000_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
